fft_out_reorder: RTL and testbench

FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

---
 rtl/fft_pkg.sv | 17 +
 rtl/fft_reorder_bank.sv | 24 ++
 rtl/fft_out_reorder.sv | 130 +++++++++++++
 tb/tb_fft_out_reorder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, read FSM states and bit-reversal helper for the FFT output reorder buffer.
package fft_pkg;
  localparam int FFT_N     = 128;
  localparam int FFT_LOG2N = 7;
  localparam int LANES     = 4;

  typedef enum logic {RD_IDLE, RD_READ} rd_state_e;

  // Reverse the low w bits of v; bits at and above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < w) r[i] = v[w-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_reorder_bank.sv
// One N-word reorder bank: four lane write ports sharing an enable, one asynchronous read port.
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int W     = 20,
  parameter int N     = FFT_N,
  parameter int LOG2N = FFT_LOG2N
) (
  input  logic                        clk,
  input  logic                        i_we,
  input  logic [LANES-1:0][LOG2N-1:0] i_waddr,
  input  logic [LANES-1:0][W-1:0]     i_wdata,
  input  logic [LOG2N-1:0]            i_raddr,
  output logic [W-1:0]                o_rdata
);
  logic [W-1:0] r_mem [N];

  // Lane addresses within one beat are always distinct, so the writes never collide.
  always_ff @(posedge clk)
    if (i_we)
      for (int l = 0; l < LANES; l++) r_mem[i_waddr[l]] <= i_wdata[l];

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: four bit-reversed lanes in per beat, one natural-order bin out per cycle.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int NBITS_out = 10,
  parameter int N         = FFT_N,
  parameter int LOG2N     = FFT_LOG2N
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_enable,
  input  logic [NBITS_out*2-1:0] fftIn0_up,
  input  logic [NBITS_out*2-1:0] fftIn0_down,
  input  logic [NBITS_out*2-1:0] fftIn1_up,
  input  logic [NBITS_out*2-1:0] fftIn1_down,
  input  logic                   i_ready,
  output logic [NBITS_out*2-1:0] fftOut,
  output logic                   o_valid,
  output logic [LOG2N-1:0]       o_index,
  output logic                   o_sof,
  output logic                   o_overflow
);
  localparam int W  = NBITS_out * 2;
  localparam int CW = LOG2N - 2;

  logic [CW-1:0]    r_wr_cnt;
  logic             r_wr_bank, r_rd_bank, r_drop;
  logic [1:0]       r_full;
  rd_state_e        r_state;
  logic [W-1:0]     r_out;
  logic [LOG2N-1:0] r_idx;
  logic             r_valid, r_sof, r_ovf;

  logic [LANES-1:0][W-1:0]     w_lanes;
  logic [LANES-1:0][LOG2N-1:0] w_waddr;
  logic [1:0][W-1:0]           w_rdata;
  logic [LOG2N-1:0]            w_raddr;
  logic [1:0]                  w_full_nxt;
  logic w_first, w_last, w_drop, w_we, w_fill;
  logic w_accept, w_release, w_nbank, w_load;

  assign w_lanes = {fftIn1_down, fftIn1_up, fftIn0_down, fftIn0_up};

  // Drop decision is taken on beat 0 and held for the rest of that frame.
  assign w_first = (r_wr_cnt == '0);
  assign w_last  = (r_wr_cnt == '1);
  assign w_drop  = w_first ? r_full[r_wr_bank] : r_drop;
  assign w_we    = in_enable && !w_drop;
  assign w_fill  = in_enable && w_last && !w_drop;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_waddr[l] = LOG2N'(bitrev(32'({r_wr_cnt, 2'(l)}), LOG2N));
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank #(.W(W), .N(N), .LOG2N(LOG2N)) u_bank (
      .clk     (clk),
      .i_we    (w_we && (r_wr_bank == 1'(b))),
      .i_waddr (w_waddr),
      .i_wdata (w_lanes),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata[b])
    );
  end

  // Read side looks one word ahead so the registered output never bubbles between banks.
  assign w_accept  = (r_state == RD_READ) && i_ready;
  assign w_release = w_accept && (r_idx == LOG2N'(N-1));
  assign w_nbank   = r_rd_bank ^ w_release;
  assign w_load    = ((r_state == RD_IDLE) && r_full[r_rd_bank]) ||
                     (w_accept && !w_release) ||
                     (w_release && r_full[!r_rd_bank]);
  assign w_raddr   = (w_accept && !w_release) ? r_idx + 1'b1 : '0;

  always_comb begin
    w_full_nxt = r_full;
    if (w_release) w_full_nxt[r_rd_bank] = 1'b0;
    if (w_fill)    w_full_nxt[r_wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
      r_drop    <= 1'b0;
      r_full    <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      r_ovf  <= in_enable && w_first && r_full[r_wr_bank];
      if (in_enable) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
        if (w_first) r_drop <= r_full[r_wr_bank];
        if (w_fill)  r_wr_bank <= !r_wr_bank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= RD_IDLE;
      r_rd_bank <= 1'b0;
      r_out     <= '0;
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_sof     <= 1'b0;
    end else begin
      r_rd_bank <= w_nbank;
      if (w_load) begin
        r_state <= RD_READ;
        r_valid <= 1'b1;
        r_out   <= w_rdata[w_nbank];
        r_idx   <= w_raddr;
        r_sof   <= (w_raddr == '0);
      end else if (w_release) begin
        r_state <= RD_IDLE;
        r_valid <= 1'b0;
        r_out   <= '0;
        r_idx   <= '0;
        r_sof   <= 1'b0;
      end
    end
  end

  assign fftOut     = r_out;
  assign o_valid    = r_valid;
  assign o_index    = r_idx;
  assign o_sof      = r_sof;
  assign o_overflow = r_ovf;
endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed-sequence bench with random frame data, checked against a bit-reversal reference model.
module tb_fft_out_reorder;
  localparam int NB = 10;
  localparam int N  = 128;
  localparam int LG = 7;
  localparam int W  = 2 * NB;

  logic clk = 1'b0, rst = 1'b0, in_enable = 1'b0, i_ready = 1'b0;
  logic [W-1:0] l0 = '0, l1 = '0, l2 = '0, l3 = '0;
  logic [W-1:0] fftOut;
  logic         o_valid, o_sof, o_overflow;
  logic [LG-1:0] o_index;

  always #5 clk = ~clk;

  fft_out_reorder #(.NBITS_out(NB), .N(N), .LOG2N(LG)) dut (
    .clk(clk), .rst(rst), .in_enable(in_enable),
    .fftIn0_up(l0), .fftIn0_down(l1), .fftIn1_up(l2), .fftIn1_down(l3),
    .i_ready(i_ready), .fftOut(fftOut), .o_valid(o_valid),
    .o_index(o_index), .o_sof(o_sof), .o_overflow(o_overflow)
  );

  typedef struct {
    logic [W-1:0] d;
    int           idx;
    logic         sof;
    int           cyc;
  } obs_t;

  int checks = 0, failures = 0;
  int cyc = 0, ovf_cnt = 0, ovf_cyc = -1, beat0_cyc = 0;
  obs_t obs_q[$];
  logic [W-1:0] frames [4][N];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    obs_t o;
    if (o_valid && i_ready) begin
      o.d = fftOut; o.idx = int'(o_index); o.sof = o_sof; o.cyc = cyc;
      obs_q.push_back(o);
    end
    if (o_overflow) begin
      ovf_cnt++;
      ovf_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic int brev(input int v);
    int r = 0;
    for (int i = 0; i < LG; i++) if (v[i]) r |= 1 << (LG - 1 - i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic gen(input int id, input bit ramp);
    for (int j = 0; j < N; j++)
      frames[id][j] = ramp ? {NB'(j), NB'(0)} : W'($urandom);
  endtask

  // Beat c carries input samples 4c..4c+3, one per lane.
  task automatic send(input int id, input bit gap);
    for (int c = 0; c < N/4; c++) begin
      in_enable = 1'b1;
      l0 = frames[id][4*c]; l1 = frames[id][4*c+1];
      l2 = frames[id][4*c+2]; l3 = frames[id][4*c+3];
      tick;
      if (c == 0) beat0_cyc = cyc;
      if (gap) begin
        in_enable = 1'b0;
        tick;
      end
    end
    in_enable = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget, input string tag);
    int t = 0;
    while (obs_q.size() < n && t < budget) begin
      tick;
      t++;
    end
    chk(tag, obs_q.size(), n);
  endtask

  // Natural-order bin k of a frame is input sample bitrev(k).
  task automatic cmp_frame(input int id, input string tag);
    obs_t o;
    for (int k = 0; k < N; k++) begin
      if (obs_q.size() == 0) begin
        chk({tag, "_short"}, k, N);
        return;
      end
      o = obs_q.pop_front();
      chk({tag, "_data"}, o.d, frames[id][brev(k)]);
      chk({tag, "_idx_sof"}, {o.idx, o.sof}, {k, (k == 0)});
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out"}, fftOut, 0);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_index"}, o_index, 0);
    chk({tag, "_sof"}, o_sof, 0);
    chk({tag, "_ovf"}, o_overflow, 0);
  endtask

  initial begin
    int c0, t;
    logic [W-1:0] held;

    // Reset state
    repeat (3) tick;
    chk_zero("reset");
    rst = 1'b1;
    tick;

    // Ramp frame: latency, sof and bit-reversed order
    gen(0, 1'b1);
    i_ready = 1'b1;
    send(0, 1'b0);
    chk("lat_pre_valid", o_valid, 0);
    tick;
    chk("lat_valid", o_valid, 1);
    chk("lat_sof", o_sof, 1);
    chk("lat_index", o_index, 0);
    wait_out(N, 300, "seq_count");
    cmp_frame(0, "seq");

    // Same frame with in_enable toggling
    send(0, 1'b1);
    wait_out(N, 400, "gap_count");
    cmp_frame(0, "gap");

    // Three random frames, continuous output stream
    gen(1, 1'b0); gen(2, 1'b0); gen(3, 1'b0);
    send(1, 1'b0);
    repeat (64) tick;
    send(2, 1'b0);
    repeat (64) tick;
    send(3, 1'b0);
    wait_out(3*N, 600, "b2b_count");
    if (obs_q.size() == 3*N) chk("b2b_span", obs_q[3*N-1].cyc - obs_q[0].cyc, 3*N-1);
    cmp_frame(1, "b2b1");
    cmp_frame(2, "b2b2");
    cmp_frame(3, "b2b3");
    chk("b2b_no_ovf", ovf_cnt, 0);

    // Backpressure at index 5
    gen(1, 1'b0);
    send(1, 1'b0);
    t = 0;
    while (!(o_valid && o_index == 5) && t < 100) begin
      tick;
      t++;
    end
    chk("bp_reach5", o_index, 5);
    i_ready = 1'b0;
    held = fftOut;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp_hold_index", o_index, 5);
      chk("bp_hold_data", fftOut, frames[1][brev(5)]);
      chk("bp_hold_stable", fftOut, held);
      chk("bp_hold_valid", o_valid, 1);
    end
    i_ready = 1'b1;
    wait_out(N, 300, "bp_count");
    cmp_frame(1, "bp");

    // Overflow: both banks filled while stalled, third frame dropped
    i_ready = 1'b0;
    gen(1, 1'b0); gen(2, 1'b0); gen(3, 1'b0);
    send(1, 1'b0);
    send(2, 1'b0);
    chk("ovf_none_yet", ovf_cnt, 0);
    send(3, 1'b0);
    c0 = beat0_cyc;
    tick;
    chk("ovf_count", ovf_cnt, 1);
    chk("ovf_cycle", ovf_cyc, c0);
    chk("ovf_stalled_out", obs_q.size(), 0);
    i_ready = 1'b1;
    wait_out(2*N, 600, "ovf_count_out");
    cmp_frame(1, "ovf1");
    cmp_frame(2, "ovf2");
    repeat (200) tick;
    chk("ovf_no_frame3", obs_q.size(), 0);
    chk("ovf_once", ovf_cnt, 1);

    // Reset at index 60 with a partial frame in flight
    gen(1, 1'b0);
    send(1, 1'b0);
    t = 0;
    while (!(o_valid && o_index == 60) && t < 200) begin
      in_enable = (t < 10);
      l0 = W'($urandom); l1 = W'($urandom); l2 = W'($urandom); l3 = W'($urandom);
      tick;
      t++;
    end
    in_enable = 1'b0;
    chk("rst_reach60", o_index, 60);
    rst = 1'b0;
    #1;
    chk_zero("rst_mid");
    tick;
    obs_q.delete();
    rst = 1'b1;
    send(0, 1'b0);
    wait_out(N, 300, "rst_count");
    cmp_frame(0, "rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
